// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encoding,
// default frame marker and the word geometry.
package imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_SYNC  = 3'd0;
  localparam state_t ST_LEN   = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_CSUM  = 3'd4;
  localparam state_t ST_RUN   = 3'd5;
  localparam state_t ST_ERROR = 3'd6;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         WORD_BYTES    = 4;

  // 8-bit additive checksum step; a frame is good when data bytes plus C wrap to zero.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects bytes into a little-endian word and keeps the running frame checksum.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_sum,
  input  logic              clr_word,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_nxt,
  output logic              word_full,
  output logic [7:0]        sum,
  output logic [1:0]        byte_cnt
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              full_q, full_d;
  logic [7:0]        sum_q, sum_d;

  // next-state for byte lanes, lane counter and word_full flag
  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    full_d     = full_q;
    if (clr_word) begin
      word_d     = '0;
      byte_cnt_d = 2'd0;
      full_d     = 1'b0;
    end else if (accept) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
      byte_cnt_d = byte_cnt_q + 2'd1;
      full_d     = (byte_cnt_q == 2'(WORD_BYTES - 1));
    end else begin
      word_d = word_q;
    end
  end

  // next-state for the running checksum
  always_comb begin
    sum_d = sum_q;
    if (clr_sum) begin
      sum_d = 8'd0;
    end else if (accept) begin
      sum_d = csum_add(sum_q, byte_in);
    end else begin
      sum_d = sum_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_cnt_q <= 2'd0;
      full_q     <= 1'b0;
      sum_q      <= 8'd0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      full_q     <= full_d;
      sum_q      <= sum_d;
    end
  end

  // word_nxt includes the byte being accepted this cycle so the write data can be registered with it
  assign word_nxt  = word_d;
  assign word_full = full_q;
  assign sum       = sum_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses A5/len/data/csum frames, writes instruction memory and
// holds the core in reset until a load with a good checksum completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int         IDX_W     = ADDR_W - 1;
  localparam logic [8:0] MAX_WORDS = 9'(1 << (ADDR_W - 2));

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [DATA_W-1:0] im_wd_q, im_wd_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic              asm_accept_s;
  logic              clr_sum_s;
  logic              clr_word_s;
  logic [DATA_W-1:0] word_nxt_s;
  logic              word_full_s;
  logic [7:0]        sum_s;
  logic [1:0]        byte_cnt_s;

  imem_loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk      (CLK),
    .rst_n    (RST),
    .clr_sum  (clr_sum_s),
    .clr_word (clr_word_s),
    .accept   (asm_accept_s),
    .byte_in  (rx_data),
    .word_nxt (word_nxt_s),
    .word_full(word_full_s),
    .sum      (sum_s),
    .byte_cnt (byte_cnt_s)
  );

  // ready decodes purely from state so the sender sees it before the edge
  always_comb begin
    case (state_q)
      ST_SYNC, ST_LEN, ST_DATA, ST_CSUM: rx_ready = 1'b1;
      default:                           rx_ready = 1'b0;
    endcase
  end

  assign accept_s = rx_valid & rx_ready;

  // frame parser and write-port sequencing
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wd_d      = im_wd_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    err_d        = err_q;
    clr_sum_s    = 1'b0;
    clr_word_s   = 1'b0;
    asm_accept_s = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (accept_s && (rx_data == SYNC_BYTE)) begin
          state_d   = ST_LEN;
          clr_sum_s = 1'b1;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_LEN: begin
        if (!accept_s) begin
          state_d = ST_LEN;
        end else if ((rx_data == 8'd0) || ({1'b0, rx_data} > MAX_WORDS)) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          cpu_hold_d = 1'b1;
        end else begin
          len_d      = IDX_W'(rx_data);
          idx_d      = '0;
          clr_word_s = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        asm_accept_s = accept_s;
        if (accept_s && (byte_cnt_s == 2'(WORD_BYTES - 1))) begin
          state_d   = ST_WRITE;
          im_we_d   = 1'b1;
          im_addr_d = ADDR_W'({idx_q, 2'b00});
          im_wd_d   = word_nxt_s;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        clr_word_s = 1'b1;
        idx_d      = idx_q + IDX_W'(1);
        // a WRITE without a full word means corrupted sequencing; fail safe
        if (!word_full_s) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          cpu_hold_d = 1'b1;
        end else if (idx_q == (len_q - IDX_W'(1))) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (!accept_s) begin
          state_d = ST_CSUM;
        end else if (csum_add(sum_s, rx_data) == 8'd0) begin
          state_d    = ST_RUN;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          cpu_hold_d = 1'b1;
        end
      end
      ST_RUN:   state_d = ST_RUN;
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d    = ST_ERROR;
        err_d      = 1'b1;
        done_d     = 1'b0;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_SYNC;
      len_q      <= '0;
      idx_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wd_q    <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wd_q    <= im_wd_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wd    = im_wd_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus hand-written
// max-length and mid-load reset sequences, with a write scoreboard.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, im_we, cpu_hold, done, err;
  logic [6:0]  im_addr;
  logic [31:0] im_wd;

  imem_loader dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wd(im_wd),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [6:0] a; logic [31:0] d; } wr_t;
  typedef struct { string nm; int n; logic [95:0] pk; bit d; bit e; int nw; logic [31:0] w0; } vec_t;

  localparam int CAP = (1 << 7) / 4;
  localparam int M_SYNC = 0, M_LEN = 1, M_DATA = 2, M_WRITE = 3, M_CSUM = 4, M_RUN = 5, M_ERR = 6;

  wr_t         exp_q[$];
  int          n_vec = 0, n_miss = 0, n_writes = 0;
  logic [6:0]  last_addr = 7'd0;
  logic [31:0] mem [0:31];
  logic        prev_we = 1'b0;
  int          m_st, m_len, m_idx, m_cnt;
  logic [31:0] m_word;
  logic [7:0]  m_sum;
  vec_t        tbl [7];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_st = M_SYNC; m_len = 0; m_idx = 0; m_cnt = 0; m_word = 32'd0; m_sum = 8'd0;
  endfunction

  // reference protocol model; pushes expected writes at the 4th-byte handshake
  function automatic void model_byte(input logic [7:0] b);
    case (m_st)
      M_SYNC: if (b == 8'hA5) begin m_st = M_LEN; m_sum = 8'd0; end
      M_LEN: begin
        if (b == 8'd0 || int'(b) > CAP) m_st = M_ERR;
        else begin m_len = int'(b); m_idx = 0; m_cnt = 0; m_word = 32'd0; m_st = M_DATA; end
      end
      M_DATA: begin
        m_word[8*m_cnt +: 8] = b;
        m_sum = m_sum + b;
        if (m_cnt == 3) begin
          exp_q.push_back('{a: 7'(m_idx * 4), d: m_word});
          m_st = M_WRITE;
        end else m_cnt++;
      end
      M_CSUM: m_st = (8'(m_sum + b) == 8'd0) ? M_RUN : M_ERR;
      default: ;
    endcase
  endfunction

  function automatic void model_write_done();
    m_cnt = 0; m_word = 32'd0; m_idx++;
    m_st = (m_idx == m_len) ? M_CSUM : M_DATA;
  endfunction

  function automatic logic [3:0] exp_status();
    logic rd;
    rd = (m_st == M_SYNC) || (m_st == M_LEN) || (m_st == M_DATA) || (m_st == M_CSUM);
    return {m_st == M_RUN, m_st == M_ERR, m_st != M_RUN, rd};
  endfunction

  function automatic vec_t mk(input string nm, input int n, input logic [95:0] pk,
                              input bit d, input bit e, input int nw, input logic [31:0] w0);
    vec_t v;
    v.nm = nm; v.n = n; v.pk = pk; v.d = d; v.e = e; v.nw = nw; v.w0 = w0;
    return v;
  endfunction

  // called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    rx_data = b; rx_valid = 1'b1;
    while (!hs && t < 20) begin
      hs = rx_ready;
      @(posedge CLK);
      if (!hs) begin @(negedge CLK); t++; end
    end
    if (!hs) begin
      rx_valid = 1'b0;
      n_vec++; n_miss++;
      $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", b, t);
    end else begin
      model_byte(b);
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("status", 64'({done, err, cpu_hold, rx_ready}), 64'(exp_status()));
      if (m_st == M_WRITE) begin
        chk("we_latency", 64'(im_we), 64'd1);
        model_write_done();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b0; rx_valid = 1'b0;
    #1 chk("reset_outputs", 64'({im_we, im_addr, im_wd, cpu_hold, done, err, rx_ready}),
           64'({1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
    exp_q.delete();
    model_reset();
    n_writes = 0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic chk_terminal(input logic d);
    rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("terminal", 64'({rx_ready, done, err, cpu_hold}), 64'({1'b0, d, ~d, ~d}));
    end
    rx_valid = 1'b0;
  endtask

  // write-port monitor: scoreboard pop, one-cycle pulse, ready low in WRITE
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (RST && im_we) begin
        chk("write_ready_low", 64'(rx_ready), 64'd0);
        chk("write_single_pulse", 64'(prev_we), 64'd0);
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected none", im_addr, im_wd);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 64'(im_addr), 64'(e.a));
          chk("write_data", 64'(im_wd), 64'(e.d));
        end
        mem[im_addr[6:2]] = im_wd;
        n_writes++;
        last_addr = im_addr;
      end
      prev_we = im_we;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b, sum;
    logic [31:0] w;
    logic [31:0] words [0:31];

    tbl[0] = mk("basic",     7, 96'({8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED}), 1'b1, 1'b0, 1, 32'h0000_0013);
    tbl[1] = mk("sync_hunt", 10, 96'({8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED}), 1'b1, 1'b0, 1, 32'h0000_0013);
    tbl[2] = mk("bad_csum",  7, 96'({8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEE}), 1'b0, 1'b1, 1, 32'h0000_0013);
    tbl[3] = mk("len_zero",  2, 96'({8'hA5, 8'h00}), 1'b0, 1'b1, 0, 32'h0);
    tbl[4] = mk("len_33",    2, 96'({8'hA5, 8'h21}), 1'b0, 1'b1, 0, 32'h0);
    tbl[5] = mk("two_words", 11, 96'({8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4}), 1'b1, 1'b0, 2, 32'h1234_5678);
    tbl[6] = mk("sync_in_data", 7, 96'({8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h6C}), 1'b1, 1'b0, 1, 32'hA5A5_A5A5);

    model_reset();
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int j = 0; j < tbl[i].n; j++) begin
        b = tbl[i].pk[8*(tbl[i].n-1-j) +: 8];
        send_byte(b, (i >= 5) ? int'($urandom_range(0, 2)) : 0);
      end
      chk({tbl[i].nm, "_done_err"}, 64'({done, err}), 64'({tbl[i].d, tbl[i].e}));
      chk({tbl[i].nm, "_nwrites"}, 64'(n_writes), 64'(tbl[i].nw));
      chk({tbl[i].nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      if (tbl[i].nw > 0) chk({tbl[i].nm, "_word0"}, 64'(mem[0]), 64'(tbl[i].w0));
      chk_terminal(tbl[i].d);
    end

    // maximum-length load with random gaps
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    sum = 8'd0;
    for (int wi = 0; wi < 32; wi++) begin
      words[wi] = {8'(wi), ~8'(wi), 8'h5A, 8'(wi * 3)};
      for (int k = 0; k < 4; k++) begin
        w = words[wi];
        b = w[8*k +: 8];
        sum = sum + b;
        send_byte(b, int'($urandom_range(0, 1)));
      end
    end
    send_byte(8'd0 - sum, 0);
    chk("max_nwrites", 64'(n_writes), 64'd32);
    chk("max_last_addr", 64'(last_addr), 64'h7C);
    chk("max_done", 64'({done, err, cpu_hold}), 64'({1'b1, 1'b0, 1'b0}));
    chk("max_word31", 64'(mem[31]), 64'(words[31]));

    // mid-load reset during word 2, then reload over the same addresses
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    w = 32'h1122_3344;
    for (int k = 0; k < 4; k++) begin b = w[8*k +: 8]; send_byte(b, 0); end
    w = 32'h5566_7788;
    for (int k = 0; k < 4; k++) begin b = w[8*k +: 8]; send_byte(b, 0); end
    send_byte(8'h99, 0);
    send_byte(8'hAA, 1);
    chk("midrst_pre_writes", 64'(n_writes), 64'd2);
    do_reset();
    words[0] = 32'hAABB_CCDD; words[1] = 32'h0102_0304; words[2] = 32'h0F0E_0D0C;
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    sum = 8'd0;
    for (int wi = 0; wi < 3; wi++) begin
      for (int k = 0; k < 4; k++) begin
        w = words[wi];
        b = w[8*k +: 8];
        sum = sum + b;
        send_byte(b, int'($urandom_range(0, 2)));
      end
    end
    send_byte(8'd0 - sum, 0);
    chk("midrst_done", 64'({done, err, cpu_hold}), 64'({1'b1, 1'b0, 1'b0}));
    chk("midrst_nwrites", 64'(n_writes), 64'd3);
    for (int wi = 0; wi < 3; wi++) chk("midrst_overwrite", 64'(mem[wi]), 64'(words[wi]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the core's instruction memory. Receives a framed byte stream over a valid/ready byte interface, assembles little-endian 32-bit words and writes them to sequential byte addresses of instruction memory through its write port. Holds the core in reset until a load completes with a valid checksum, then releases it. Sits beside the single-cycle RISC-V top, between a serial receiver and the instruction memory write port.

Parameters:
DATA_W, 32, instruction word width; fixed at 4 bytes.
ADDR_W, 7, byte-address width of instruction memory; capacity is 2^ADDR_W/4 words (32 at default).
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-low reset.
rx_data  input  8  incoming byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader accepts a byte this cycle.
im_we  output  1  instruction memory write enable, one-cycle pulse per word.
im_addr  output  ADDR_W  byte address of the write; always word-aligned.
im_wd  output  DATA_W  write data.
cpu_hold  output  1  high keeps the core in reset.
done  output  1  load completed with a good checksum.
err  output  1  load failed; terminal until reset.

Behaviour:
- Reset (RST=0, async): state=SYNC; im_we=0, im_addr=0, im_wd=0, cpu_hold=1, done=0, err=0, all counters and the checksum cleared. rx_ready=1, since it decodes from the SYNC state.
- A byte is accepted on the rising edge where rx_valid & rx_ready. rx_ready is combinational from state: 1 in SYNC, LEN, DATA and CSUM; 0 in WRITE, RUN and ERROR.
- SYNC:
  - Accepted byte equals SYNC_BYTE: go to LEN and clear the checksum.
  - Any other byte: discarded, remain in SYNC.
- LEN:
  - Accepted byte L is the word count.
  - L==0 or L > 2^ADDR_W/4: go to ERROR.
  - Otherwise store L, word_idx=0, byte_cnt=0, go to DATA.
- DATA:
  - Each accepted byte is placed in the word at bits [8*byte_cnt+7 : 8*byte_cnt] (little-endian) and added to the 8-bit running sum, mod 256.
  - After the 4th byte (byte_cnt==3), go to WRITE.
- WRITE (exactly one cycle, rx_ready=0):
  - im_we=1, im_addr=word_idx*4, im_wd=assembled word.
  - Next cycle: im_we=0; word_idx increments; byte_cnt clears.
  - word_idx==L-1: go to CSUM; otherwise go to DATA.
  - Latency: im_we is high in the cycle after the 4th byte handshake.
  - im_addr and im_wd hold their last written values outside WRITE.
- CSUM: accept one byte C.
  - (running_sum + C) mod 256 == 0: go to RUN.
  - Otherwise go to ERROR.
- RUN: cpu_hold=0, done=1, registered, asserted the cycle after C is accepted. Terminal until reset; rx bytes are not accepted.
- ERROR: err=1, cpu_hold=1, done=0. Terminal until reset.
- Maximum-length load (L=32 at default): the last write goes to im_addr=0x7C. The word_idx counter is ADDR_W-1 bits wide, so it cannot overflow before the L check.
- Reset mid-operation: immediate return to reset values. Words already written stay in memory (no clearing); cpu_hold is reasserted.
- rx_valid may drop between bytes; the state machine only advances on handshakes.

Decomposition:
- Shared package:
  - State encoding constants: SYNC, LEN, DATA, WRITE, CSUM, RUN, ERROR.
  - SYNC_BYTE default.
  - Word byte-count constant (4).
- One natural sub-module: word_assembler.
  - Contains the byte-lane shift register, byte_cnt, a word_full flag and the running 8-bit checksum.
  - Controlled by accept and clear strobes from the loader state machine.

Test Plan:
- Basic load: stream A5, 01, 13 00 00 00, ED -> one im_we pulse with im_addr=0x00 and im_wd=0x00000013; done=1 and cpu_hold=0 one cycle after the ED handshake.
- Sync hunt: stream 00 FF 3C, then a valid frame -> the first three bytes are ignored and the load completes normally.
- Bad checksum: stream A5, 01, 13 00 00 00, EE -> err=1, done=0, cpu_hold=1, rx_ready=0 from then on.
- Length bounds: L=00 -> ERROR; L=21 (33) -> ERROR; L=20 (32) with a correct checksum -> 32 writes at addresses 0x00..0x7C, then RUN.
- Backpressure and gaps: insert random rx_valid gaps; check rx_ready=0 in every WRITE cycle; check a byte presented during WRITE is held and accepted on the next cycle.
- Mid-load reset: drop RST during DATA of word 2 -> outputs return to reset values at once; a subsequent full frame loads correctly and earlier words are overwritten at the same addresses.
